operand_hazard_unit: RTL and testbench

//  Decode-stage operand supply for the pipelined CPU. Tracks in-flight GRF writers in E/M/W,

---
 rtl/operand_hazard_unit_pkg.sv | 17 +
 rtl/operand_hazard_unit_stage_reg.sv | 38 +++
 rtl/operand_hazard_unit.sv | 90 +++++++++
 tb/tb_operand_hazard_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_hazard_unit_pkg.sv
// Shared encodings for the decode-stage operand hazard unit:
// forwarding source select and the Tnew value of each instruction class.
package operand_hazard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_sel_t;

  // Cycles from E entry until the result can be forwarded.
  localparam logic [1:0] TNEW_JAL  = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

endpackage

// File: rtl/operand_hazard_unit_stage_reg.sv
// One in-flight GRF writer record {valid, a3, tnew}, advanced every cycle.
// DEC selects whether tnew counts down (saturating) while the record is loaded.
module operand_hazard_unit_stage_reg #(
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 2,
  parameter bit DEC    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_a3,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              valid,
  output logic [ADDR_W-1:0] a3,
  output logic [TNEW_W-1:0] tnew
);

  logic [TNEW_W-1:0] tnew_next;

  always_comb begin
    tnew_next = in_tnew;
    if (DEC && (in_tnew != '0)) tnew_next = in_tnew - TNEW_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      a3    <= '0;
      tnew  <= '0;
    end else begin
      valid <= in_valid & ~bubble;
      a3    <= in_a3;
      tnew  <= tnew_next;
    end
  end

endmodule

// File: rtl/operand_hazard_unit.sv
// Decode-stage operand supply: tracks E/M/W writers, stalls on results not yet
// produced and forwards the youngest ready value over the GRF read data.
module operand_hazard_unit
  import operand_hazard_unit_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int TNEW_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_wr_en,
  input  logic [ADDR_W-1:0] d_a3,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] d_rt,
  input  logic [DATA_W-1:0] grf_rd1,
  input  logic [DATA_W-1:0] grf_rd2,
  input  logic [DATA_W-1:0] fwd_e_data,
  input  logic [DATA_W-1:0] fwd_m_data,
  input  logic [DATA_W-1:0] fwd_w_data,
  output logic              stall,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [1:0]        fwd_sel_rs,
  output logic [1:0]        fwd_sel_rt
);

  logic              e_valid, m_valid, w_valid;
  logic [ADDR_W-1:0] e_a3, m_a3, w_a3;
  logic [TNEW_W-1:0] e_tnew, m_tnew, w_tnew;
  logic              stall_rs, stall_rt;

  operand_hazard_unit_stage_reg #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W), .DEC(1'b0)) u_e (
    .clk(clk), .reset(reset), .bubble(stall),
    .in_valid(d_wr_en && (d_a3 != '0)), .in_a3(d_a3), .in_tnew(d_tnew),
    .valid(e_valid), .a3(e_a3), .tnew(e_tnew)
  );

  operand_hazard_unit_stage_reg #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W), .DEC(1'b1)) u_m (
    .clk(clk), .reset(reset), .bubble(1'b0),
    .in_valid(e_valid), .in_a3(e_a3), .in_tnew(e_tnew),
    .valid(m_valid), .a3(m_a3), .tnew(m_tnew)
  );

  operand_hazard_unit_stage_reg #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W), .DEC(1'b1)) u_w (
    .clk(clk), .reset(reset), .bubble(1'b0),
    .in_valid(m_valid), .in_a3(m_a3), .in_tnew(m_tnew),
    .valid(w_valid), .a3(w_a3), .tnew(w_tnew)
  );

  // Youngest matching stage wins; returns {stall, select}.
  function automatic logic [2:0] resolve(input logic [ADDR_W-1:0] r);
    logic [2:0] res;
    res = {1'b0, FWD_GRF};
    if (r != '0) begin
      if (e_valid && (e_a3 == r))      res = {(e_tnew != '0), FWD_E};
      else if (m_valid && (m_a3 == r)) res = {(m_tnew != '0), FWD_M};
      else if (w_valid && (w_a3 == r)) res = {(w_tnew != '0), FWD_W};
    end
    return res;
  endfunction

  always_comb begin
    {stall_rs, fwd_sel_rs} = resolve(d_rs);
    {stall_rt, fwd_sel_rt} = resolve(d_rt);
    stall = stall_rs | stall_rt;
  end

  always_comb begin
    rs_data = grf_rd1;
    case (fwd_sel_rs)
      FWD_E:   rs_data = fwd_e_data;
      FWD_M:   rs_data = fwd_m_data;
      FWD_W:   rs_data = fwd_w_data;
      default: rs_data = grf_rd1;
    endcase
  end

  always_comb begin
    rt_data = grf_rd2;
    case (fwd_sel_rt)
      FWD_E:   rt_data = fwd_e_data;
      FWD_M:   rt_data = fwd_m_data;
      FWD_W:   rt_data = fwd_w_data;
      default: rt_data = grf_rd2;
    endcase
  end

endmodule

// File: tb/tb_operand_hazard_unit.sv
// Bench for operand_hazard_unit: issue-history model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_operand_hazard_unit;

  logic        clk;
  logic        reset;
  logic        d_wr_en;
  logic [4:0]  d_a3;
  logic [1:0]  d_tnew;
  logic [4:0]  d_rs, d_rt;
  logic [31:0] grf_rd1, grf_rd2, fwd_e_data, fwd_m_data, fwd_w_data;
  logic        stall;
  logic [31:0] rs_data, rt_data;
  logic [1:0]  fwd_sel_rs, fwd_sel_rt;

  int tests = 0;
  int fails = 0;

  operand_hazard_unit dut (
    .clk(clk), .reset(reset), .d_wr_en(d_wr_en), .d_a3(d_a3), .d_tnew(d_tnew),
    .d_rs(d_rs), .d_rt(d_rt), .grf_rd1(grf_rd1), .grf_rd2(grf_rd2),
    .fwd_e_data(fwd_e_data), .fwd_m_data(fwd_m_data), .fwd_w_data(fwd_w_data),
    .stall(stall), .rs_data(rs_data), .rt_data(rt_data),
    .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of issued writers with the edge number at which they entered E.
  // Age in stages = edges elapsed since entry; remaining latency = tnew - age.
  typedef struct {
    int edge_no;
    int a3;
    int tnew;
  } iss_t;

  iss_t hist[$];
  int   edges = 0;

  task automatic model_resolve(input int r, output int sel, output bit stl);
    bit found;
    int age;
    sel = 0;
    stl = 1'b0;
    found = 1'b0;
    if (r != 0) begin
      for (int i = hist.size() - 1; i >= 0; i--) begin
        age = edges - 1 - hist[i].edge_no;
        if (!found && age >= 0 && age <= 2 && hist[i].a3 == r) begin
          found = 1'b1;
          if (hist[i].tnew - age > 0) stl = 1'b1;
          else sel = age + 1;
        end
      end
    end
  endtask

  task automatic model_stall(output bit stl);
    int s1, s2;
    bit a, b;
    model_resolve(int'(d_rs), s1, a);
    model_resolve(int'(d_rt), s2, b);
    stl = a | b;
  endtask

  initial begin
    bit   stl;
    iss_t e;
    forever begin
      @(posedge clk);
      if (reset) begin
        hist.delete();
      end else begin
        model_stall(stl);
        if (!stl && d_wr_en && d_a3 != 5'd0) begin
          e.edge_no = edges;
          e.a3      = int'(d_a3);
          e.tnew    = int'(d_tnew);
          hist.push_back(e);
        end
      end
      edges++;
      while (hist.size() > 0 && (edges - 1 - hist[0].edge_no) > 2) void'(hist.pop_front());
    end
  end

  function automatic logic [31:0] pick(input int sel, input logic [31:0] grf);
    case (sel)
      1:       return fwd_e_data;
      2:       return fwd_m_data;
      3:       return fwd_w_data;
      default: return grf;
    endcase
  endfunction

  initial begin
    int s_rs, s_rt;
    bit st_rs, st_rt;
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_resolve(int'(d_rs), s_rs, st_rs);
      model_resolve(int'(d_rt), s_rt, st_rt);
      check("model_stall", {31'd0, stall}, {31'd0, st_rs | st_rt});
      if (!(st_rs | st_rt)) begin
        check("model_sel_rs", {30'd0, fwd_sel_rs}, s_rs);
        check("model_sel_rt", {30'd0, fwd_sel_rt}, s_rt);
        check("model_rs_data", rs_data, pick(s_rs, grf_rd1));
        check("model_rt_data", rt_data, pick(s_rt, grf_rd2));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [4:0] a3, input logic [1:0] tn);
    d_wr_en = 1'b1;
    d_a3    = a3;
    d_tnew  = tn;
    d_rs    = 5'd0;
    d_rt    = 5'd0;
    cyc();
    d_wr_en = 1'b0;
  endtask

  task automatic flush();
    d_wr_en = 1'b0;
    d_rs    = 5'd0;
    d_rt    = 5'd0;
    repeat (3) cyc();
  endtask

  initial begin
    reset      = 1'b1;
    d_wr_en    = 1'b0;
    d_a3       = 5'd0;
    d_tnew     = 2'd0;
    d_rs       = 5'd2;
    d_rt       = 5'd0;
    grf_rd1    = 32'h0000_1234;
    grf_rd2    = 32'h0000_5678;
    fwd_e_data = 32'hE0E0_E0E0;
    fwd_m_data = 32'hDEAD_BEEF;
    fwd_w_data = 32'h0000_CAFE;

    // 1: reset state
    cyc();
    reset = 1'b0;
    #1;
    check("t1_stall", {31'd0, stall}, 32'd0);
    check("t1_sel_rs", {30'd0, fwd_sel_rs}, 32'd0);
    check("t1_rs_data", rs_data, 32'h0000_1234);

    // 2: ALU result, one stall then forward from M
    issue(5'd5, 2'd1);
    d_rs = 5'd5;
    #1 check("t2_stall0", {31'd0, stall}, 32'd1);
    cyc();
    #1;
    check("t2_stall1", {31'd0, stall}, 32'd0);
    check("t2_sel_rs", {30'd0, fwd_sel_rs}, 32'd2);
    check("t2_rs_data", rs_data, 32'hDEAD_BEEF);
    flush();

    // 3: load, two stalls then forward from W on rt
    issue(5'd8, 2'd2);
    d_rt = 5'd8;
    #1 check("t3_stall0", {31'd0, stall}, 32'd1);
    cyc();
    #1 check("t3_stall1", {31'd0, stall}, 32'd1);
    cyc();
    #1;
    check("t3_stall2", {31'd0, stall}, 32'd0);
    check("t3_sel_rt", {30'd0, fwd_sel_rt}, 32'd3);
    check("t3_rt_data", rt_data, 32'h0000_CAFE);
    flush();

    // 4: jal, forward from E without stall
    issue(5'd31, 2'd0);
    d_rs = 5'd31;
    #1;
    check("t4_stall", {31'd0, stall}, 32'd0);
    check("t4_sel_rs", {30'd0, fwd_sel_rs}, 32'd1);
    check("t4_rs_data", rs_data, 32'hE0E0_E0E0);
    flush();

    // 5: register 0 never tracked
    issue(5'd0, 2'd2);
    d_rs = 5'd0;
    #1;
    check("t5_stall", {31'd0, stall}, 32'd0);
    check("t5_sel_rs", {30'd0, fwd_sel_rs}, 32'd0);
    check("t5_rs_data", rs_data, 32'h0000_1234);
    flush();

    // 6a: same register in E and M, E is youngest
    d_wr_en = 1'b1; d_a3 = 5'd3; d_tnew = 2'd0;
    cyc();
    cyc();
    d_wr_en = 1'b0;
    d_rs = 5'd3;
    d_rt = 5'd3;
    #1;
    check("t6_stall", {31'd0, stall}, 32'd0);
    check("t6_sel_rs", {30'd0, fwd_sel_rs}, 32'd1);
    check("t6_sel_rt", {30'd0, fwd_sel_rt}, 32'd1);
    check("t6_rt_data", rt_data, 32'hE0E0_E0E0);
    flush();

    // 6b: load in E, reset during the stall clears everything
    issue(5'd3, 2'd2);
    d_rs = 5'd3;
    #1 check("t6b_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("t6b_stall_after_rst", {31'd0, stall}, 32'd0);
    check("t6b_sel_rs", {30'd0, fwd_sel_rs}, 32'd0);
    check("t6b_sel_rt", {30'd0, fwd_sel_rt}, 32'd0);
    check("t6b_rs_data", rs_data, 32'h0000_1234);
    flush();

    // 7: instruction held in D during a stall is issued exactly once afterwards
    issue(5'd7, 2'd1);
    d_wr_en = 1'b1; d_a3 = 5'd9; d_tnew = 2'd1; d_rs = 5'd7;
    #1 check("t7_stall", {31'd0, stall}, 32'd1);
    cyc();
    #1;
    check("t7_nostall", {31'd0, stall}, 32'd0);
    check("t7_sel_rs", {30'd0, fwd_sel_rs}, 32'd2);
    cyc();
    d_wr_en = 1'b0;
    d_rs = 5'd9;
    #1 check("t7_dep_stall", {31'd0, stall}, 32'd1);
    cyc();
    #1 check("t7_dep_sel", {30'd0, fwd_sel_rs}, 32'd2);
    flush();

    // Mixed traffic on a small register set, checked by the model
    for (int i = 0; i < 80; i++) begin
      d_wr_en    = 1'($urandom_range(0, 1));
      d_a3       = 5'($urandom_range(0, 3));
      d_tnew     = 2'($urandom_range(0, 2));
      d_rs       = 5'($urandom_range(0, 3));
      d_rt       = 5'($urandom_range(0, 3));
      grf_rd1    = $urandom;
      grf_rd2    = $urandom;
      fwd_e_data = $urandom;
      fwd_m_data = $urandom;
      fwd_w_data = $urandom;
      reset      = (i == 40);
      cyc();
    end
    reset = 1'b0;
    flush();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
